// File: rtl/adc_decim_frontend.sv
// Dual-channel 12-bit ADC decimator with sign extension and adc_en cadence watchdog.
// Define ADC_DECIM_AVG_EN for boxcar-sum decimation; otherwise the closing sample is picked.
module adc_decim_frontend #(
    parameter int DECIM      = 5,
    parameter bit OFFSET_BIN = 1'b0,
    parameter int MAX_GAP    = 15
) (
    input  logic        clks,
    input  logic        rst,
    input  logic        adc_en,
    input  logic [11:0] ADC_A,
    input  logic [11:0] ADC_B,
    input  logic        resync,
    output logic        data_out_en,
    output logic [15:0] DATA_OUT_A,
    output logic [15:0] DATA_OUT_B,
    output logic        gap_err
);

    localparam int W  = 12 + $clog2(DECIM);
    localparam int PW = $clog2(DECIM);
    localparam int GW = $clog2(MAX_GAP + 2);

    logic signed [11:0] cond_a, cond_b;
    logic [PW-1:0]      phase;
    logic               closing;
    logic [15:0]        res_a, res_b;
    logic               armed;
    logic [GW-1:0]      gap_cnt;

    assign cond_a = {ADC_A[11] ^ OFFSET_BIN, ADC_A[10:0]};
    assign cond_b = {ADC_B[11] ^ OFFSET_BIN, ADC_B[10:0]};

    // A resync in the closing cycle wins: the group is discarded, not emitted.
    assign closing = adc_en && !resync && (phase == PW'(DECIM - 1));

    always_ff @(posedge clks or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (adc_en) begin
            if (resync)       phase <= PW'(1);
            else if (closing) phase <= '0;
            else              phase <= phase + PW'(1);
        end else if (resync) begin
            phase <= '0;
        end
    end

`ifdef ADC_DECIM_AVG_EN
    logic signed [W-1:0] acc_a, acc_b;
    logic signed [W-1:0] sum_a, sum_b;

    // A resync with adc_en makes this sample the first of a fresh group.
    assign sum_a = (resync ? W'(0) : acc_a) + W'(cond_a);
    assign sum_b = (resync ? W'(0) : acc_b) + W'(cond_b);
    assign res_a = 16'(sum_a);
    assign res_b = 16'(sum_b);

    always_ff @(posedge clks or posedge rst) begin
        if (rst) begin
            acc_a <= '0;
            acc_b <= '0;
        end else if (adc_en) begin
            if (closing) begin
                acc_a <= '0;
                acc_b <= '0;
            end else begin
                acc_a <= sum_a;
                acc_b <= sum_b;
            end
        end else if (resync) begin
            acc_a <= '0;
            acc_b <= '0;
        end
    end
`else
    assign res_a = {cond_a, 4'b0000};
    assign res_b = {cond_b, 4'b0000};
`endif

    always_ff @(posedge clks or posedge rst) begin
        if (rst) begin
            data_out_en <= 1'b0;
            DATA_OUT_A  <= '0;
            DATA_OUT_B  <= '0;
        end else begin
            data_out_en <= closing;
            if (closing) begin
                DATA_OUT_A <= res_a;
                DATA_OUT_B <= res_b;
            end
        end
    end

    // Watchdog stays idle until the first sample after reset/resync.
    always_ff @(posedge clks or posedge rst) begin
        if (rst) begin
            armed   <= 1'b0;
            gap_cnt <= '0;
            gap_err <= 1'b0;
        end else if (resync) begin
            armed   <= adc_en;
            gap_cnt <= '0;
            gap_err <= 1'b0;
        end else if (adc_en) begin
            armed   <= 1'b1;
            gap_cnt <= '0;
        end else if (armed && gap_cnt != GW'(MAX_GAP + 1)) begin
            gap_cnt <= gap_cnt + GW'(1);
            if (gap_cnt == GW'(MAX_GAP)) gap_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_decim_frontend.sv
// Bench for adc_decim_frontend: spec vector table, corner sequences, randomized run vs group model.
module tb_adc_decim_frontend;

    localparam int DECIM      = 5;
    localparam bit OFFSET_BIN = 1'b0;
    localparam int MAX_GAP    = 15;

    logic        clks = 1'b0;
    logic        rst = 1'b0;
    logic        adc_en = 1'b0;
    logic [11:0] ADC_A = '0;
    logic [11:0] ADC_B = '0;
    logic        resync = 1'b0;
    logic        data_out_en;
    logic [15:0] DATA_OUT_A, DATA_OUT_B;
    logic        gap_err;

    adc_decim_frontend #(.DECIM(DECIM), .OFFSET_BIN(OFFSET_BIN), .MAX_GAP(MAX_GAP)) dut (
        .clks(clks), .rst(rst), .adc_en(adc_en), .ADC_A(ADC_A), .ADC_B(ADC_B),
        .resync(resync), .data_out_en(data_out_en), .DATA_OUT_A(DATA_OUT_A),
        .DATA_OUT_B(DATA_OUT_B), .gap_err(gap_err)
    );

    always #5 clks = ~clks;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    // Reference model: samples of the open group, last emitted result, watchdog state.
    int          qa[$], qb[$];
    logic        m_en;
    logic [15:0] m_a, m_b;
    logic        m_gap;
    bit          m_armed;
    int          m_idle;

    typedef struct {
        logic [11:0] a, b;
        logic [15:0] avg_a, avg_b, pick_a, pick_b;
    } vec_t;
    vec_t vt[5];

    function automatic int cond12(input logic [11:0] x);
        logic [11:0] y;
        y = x;
        if (OFFSET_BIN) y[11] = ~y[11];
        return int'($signed(y));
    endfunction

    task automatic model_reset();
        qa.delete(); qb.delete();
        m_en = 0; m_a = '0; m_b = '0; m_gap = 0; m_armed = 0; m_idle = 0;
    endtask

    task automatic model_update(input logic en, input logic [11:0] a, input logic [11:0] b,
                                input logic rs);
        int sa, sb;
        m_en = 0;
        if (rs) begin
            qa.delete(); qb.delete();
            m_gap = 0; m_idle = 0; m_armed = 0;
        end
        if (en) begin
            qa.push_back(cond12(a));
            qb.push_back(cond12(b));
            m_armed = 1;
            m_idle = 0;
            if (qa.size() == DECIM) begin
`ifdef ADC_DECIM_AVG_EN
                sa = 0; sb = 0;
                foreach (qa[i]) sa += qa[i];
                foreach (qb[i]) sb += qb[i];
`else
                sa = qa[DECIM-1] * 16;
                sb = qb[DECIM-1] * 16;
`endif
                m_a = 16'(sa);
                m_b = 16'(sb);
                m_en = 1;
                qa.delete(); qb.delete();
            end
        end else if (m_armed) begin
            if (m_idle < MAX_GAP + 1) m_idle++;
            if (m_idle == MAX_GAP + 1) m_gap = 1;
        end
    endtask

    task automatic check_model(input string name);
        checks++;
        if (data_out_en !== m_en || DATA_OUT_A !== m_a || DATA_OUT_B !== m_b || gap_err !== m_gap) begin
            errors++;
            $display("FAIL %s t=%0t: got en=%b a=%h b=%h gap=%b, expected en=%b a=%h b=%h gap=%b",
                     name, $time, data_out_en, DATA_OUT_A, DATA_OUT_B, gap_err,
                     m_en, m_a, m_b, m_gap);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic [11:0] a, input logic [11:0] b, input logic rs);
        adc_en = en; ADC_A = a; ADC_B = b; resync = rs;
        @(posedge clks);
        #1;
        model_update(en, a, b, rs);
        check_model("model");
        if (data_out_en === 1'b1) strobes++;
        adc_en = 0; resync = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'h000, 12'h000, 1'b0);
    endtask

    task automatic sample(input logic [11:0] a, input logic [11:0] b);
        step(1'b1, a, b, 1'b0);
        idle(9);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1;
        #1;
        model_reset();
        check_model("reset");
        @(posedge clks);
        #1;
        rst = 0;
        strobes = 0;
    endtask

    initial begin
        vt[0] = '{12'h100, 12'hFFF, 16'h0500, 16'hFFFB, 16'h1000, 16'hFFF0};
        vt[1] = '{12'h800, 12'h7FF, 16'hD800, 16'h27FB, 16'h8000, 16'h7FF0};
        vt[2] = '{12'h7FF, 12'h800, 16'h27FB, 16'hD800, 16'h7FF0, 16'h8000};
        vt[3] = '{12'h000, 12'h001, 16'h0000, 16'h0005, 16'h0000, 16'h0010};
        vt[4] = '{12'hFFE, 12'h003, 16'hFFF6, 16'h000F, 16'hFFE0, 16'h0030};

        model_reset();
        #2;
        do_reset();

        // Constant-input groups: strobe after the 5th sample with the tabulated value.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int s = 0; s < DECIM; s++) begin
                step(1'b1, vt[v].a, vt[v].b, 1'b0);
                if (s < DECIM - 1) idle(9);
            end
            check_val($sformatf("vec%0d_en", v), 32'(data_out_en), 32'd1);
`ifdef ADC_DECIM_AVG_EN
            check_val($sformatf("vec%0d_a", v), 32'(DATA_OUT_A), 32'(vt[v].avg_a));
            check_val($sformatf("vec%0d_b", v), 32'(DATA_OUT_B), 32'(vt[v].avg_b));
`else
            check_val($sformatf("vec%0d_a", v), 32'(DATA_OUT_A), 32'(vt[v].pick_a));
            check_val($sformatf("vec%0d_b", v), 32'(DATA_OUT_B), 32'(vt[v].pick_b));
`endif
            idle(49);
            check_val($sformatf("vec%0d_period", v), 32'(strobes), 32'd1);
            step(1'b1, vt[v].a, vt[v].b, 1'b0);
            check_val($sformatf("vec%0d_hold", v), 32'(data_out_en), 32'd0);
        end

        // Ramp with resync after sample 3: first group is samples 4..8.
        do_reset();
        for (int s = 1; s <= 3; s++) sample(12'(s), 12'(s));
        step(1'b0, 12'h000, 12'h000, 1'b1);
        for (int s = 4; s <= 8; s++) begin
            step(1'b1, 12'(s), 12'(s), 1'b0);
            if (s < 8) idle(9);
        end
`ifdef ADC_DECIM_AVG_EN
        check_val("ramp_a", 32'(DATA_OUT_A), 32'h001E);
`else
        check_val("ramp_a", 32'(DATA_OUT_A), 32'h0080);
`endif
        check_val("ramp_strobes", 32'(strobes), 32'd1);

        // Resync coinciding with a closing sample: no strobe, sample starts new group.
        do_reset();
        for (int s = 0; s < DECIM - 1; s++) sample(12'h010, 12'h020);
        step(1'b1, 12'h011, 12'h021, 1'b1);
        check_val("resync_close_en", 32'(data_out_en), 32'd0);
        idle(9);
        for (int s = 0; s < DECIM - 1; s++) sample(12'h001, 12'h002);
        check_val("resync_close_strobes", 32'(strobes), 32'd1);

        // Gap watchdog: set on the 16th idle cycle, sticky, cleared by resync.
        do_reset();
        idle(30);
        check_val("gap_unarmed", 32'(gap_err), 32'd0);
        step(1'b1, 12'h005, 12'h006, 1'b0);
        idle(MAX_GAP);
        check_val("gap_15", 32'(gap_err), 32'd0);
        idle(1);
        check_val("gap_16", 32'(gap_err), 32'd1);
        idle(4);
        step(1'b1, 12'h005, 12'h006, 1'b0);
        check_val("gap_sticky", 32'(gap_err), 32'd1);
        step(1'b0, 12'h000, 12'h000, 1'b1);
        check_val("gap_resync", 32'(gap_err), 32'd0);

        // Reset after the 2nd sample of a group.
        do_reset();
        for (int s = 0; s < DECIM + 2; s++) sample(12'h123, 12'h456);
        rst = 1;
        #1;
        check_val("rst_mid_out", {13'd0, data_out_en, gap_err, 1'b0, DATA_OUT_A}, 32'd0);
        check_val("rst_mid_b", 32'(DATA_OUT_B), 32'd0);
        model_reset();
        @(posedge clks);
        #1;
        rst = 0;
        strobes = 0;
        for (int s = 0; s < DECIM - 1; s++) sample(12'h00A, 12'h00B);
        check_val("rst_mid_nostrobe", 32'(strobes), 32'd0);
        step(1'b1, 12'h00A, 12'h00B, 1'b0);
        check_val("rst_mid_strobe", 32'(data_out_en), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            logic en, rs;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                en = ($urandom_range(0, 3) == 0);
                if ((i / 500) % 3 == 2) en = ($urandom_range(0, 24) == 0);
                rs = ($urandom_range(0, 149) == 0);
                step(en, 12'($urandom), 12'($urandom), rs);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
